snd_fifo: RTL and testbench



---
 rtl/snd_fifo.sv | 180 ++++++++++++++++++
 tb/tb_snd_fifo.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/snd_fifo.sv
// Stereo L/R sample FIFO between the CPU bus sound window and the SPI DAC driver.
// Optional underrun counter on addr 3 is built when SND_FIFO_STATS_EN is defined.
//
// state  | meaning
// S_IDLE | bus idle or single-cycle write; accepts new bus cycles
// S_RD1  | read data registered, wt released
// S_WFULL| DATA write stalled on a full FIFO, waiting for a free slot
module snd_fifo #(
  parameter int          DEPTH_LOG2  = 6,
  parameter logic [15:0] IDLE_SAMPLE = 16'h0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  input  logic        wr,
  input  logic [1:0]  addr,
  input  logic [31:0] data_in,
  output logic [31:0] data_out,
  output logic        wt,
  input  logic        next_sample,
  output logic [15:0] ldata,
  output logic [15:0] rdata,
  output logic        irq
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int PW    = DEPTH_LOG2 + 1;
  localparam logic [PW-1:0] LVL_FULL = PW'(DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_RD1, S_WFULL} state_t;

  state_t        state, state_nxt;
  logic [31:0]   mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr, level, thr;
  logic          ie, underrun;
  logic          empty, full, pop_fire, udr_ev, space;
  logic          push, rd_load, ctrl_wr, flush, udr_clr;
  logic [31:0]   head, rd_mux;
`ifdef SND_FIFO_STATS_EN
  logic [15:0]   udr_cnt;
  logic          stats_clr;
`endif

  assign level    = wr_ptr - rd_ptr;
  assign empty    = (level == '0);
  assign full     = (level == LVL_FULL);
  assign head     = mem[rd_ptr[DEPTH_LOG2-1:0]];
  assign flush    = ctrl_wr & data_in[17];
  assign udr_clr  = ctrl_wr & data_in[18];
  assign pop_fire = next_sample & ~empty & ~flush;
  assign udr_ev   = next_sample & empty;
  // a pop in the same cycle frees the slot a full-FIFO push needs
  assign space    = ~full | pop_fire;

  always_comb begin
    state_nxt = state;
    wt        = 1'b0;
    push      = 1'b0;
    rd_load   = 1'b0;
    ctrl_wr   = 1'b0;
`ifdef SND_FIFO_STATS_EN
    stats_clr = 1'b0;
`endif
    if (reset) begin
      case (state)
        S_IDLE: begin
          if (en) begin
            if (!wr) begin
              wt        = 1'b1;
              rd_load   = 1'b1;
              state_nxt = S_RD1;
            end else if (addr == 2'd0) begin
              if (space) begin
                push = 1'b1;
              end else begin
                wt        = 1'b1;
                state_nxt = S_WFULL;
              end
            end else if (addr == 2'd2) begin
              ctrl_wr = 1'b1;
            end
`ifdef SND_FIFO_STATS_EN
            else if (addr == 2'd3) begin
              stats_clr = 1'b1;
            end
`endif
          end
        end
        S_RD1: state_nxt = S_IDLE;
        S_WFULL: begin
          if (!en) begin
            state_nxt = S_IDLE;
          end else if (space) begin
            push      = 1'b1;
            state_nxt = S_IDLE;
          end else begin
            wt = 1'b1;
          end
        end
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  always_comb begin
    rd_mux = '0;
    case (addr)
      2'd1: begin
        rd_mux[PW-1:0] = level;
        rd_mux[16]     = empty;
        rd_mux[17]     = full;
        rd_mux[18]     = underrun;
      end
      2'd2: begin
        rd_mux[PW-1:0] = thr;
        rd_mux[16]     = ie;
      end
`ifdef SND_FIFO_STATS_EN
      2'd3: rd_mux[15:0] = udr_cnt;
`endif
      default: rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[DEPTH_LOG2-1:0]] <= data_in;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= S_IDLE;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      ldata    <= IDLE_SAMPLE;
      rdata    <= IDLE_SAMPLE;
      data_out <= '0;
      irq      <= 1'b0;
      ie       <= 1'b0;
      thr      <= '0;
      underrun <= 1'b0;
    end else begin
      state <= state_nxt;
      irq   <= ie & (level <= thr);
      if (rd_load) data_out <= rd_mux;
      if (ctrl_wr) begin
        thr <= data_in[PW-1:0];
        ie  <= data_in[16];
      end
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        ldata  <= IDLE_SAMPLE;
        rdata  <= IDLE_SAMPLE;
      end else begin
        if (push) wr_ptr <= wr_ptr + 1'b1;
        if (pop_fire) begin
          rd_ptr <= rd_ptr + 1'b1;
          ldata  <= head[31:16];
          rdata  <= head[15:0];
        end
      end
      // a fresh underrun outranks a clear in the same cycle
      if (udr_ev) underrun <= 1'b1;
      else if (udr_clr) underrun <= 1'b0;
    end
  end

`ifdef SND_FIFO_STATS_EN
  always_ff @(posedge clk) begin
    if (!reset) begin
      udr_cnt <= '0;
    end else if (stats_clr) begin
      udr_cnt <= '0;
    end else if (udr_ev && udr_cnt != 16'hFFFF) begin
      udr_cnt <= udr_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_snd_fifo.sv
// Directed bench for snd_fifo: bus protocol, push/pop, full stall, underrun, irq, flush, reset.
module tb_snd_fifo;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        en = 1'b0;
  logic        wr = 1'b0;
  logic [1:0]  addr = 2'd0;
  logic [31:0] data_in = '0;
  logic [31:0] data_out;
  logic        wt;
  logic        next_sample = 1'b0;
  logic [15:0] ldata, rdata;
  logic        irq;

  int n_chk = 0;
  int n_fail = 0;
  logic [31:0] rd;
  logic        rd_wt0, rd_wt1;

  snd_fifo dut (
    .clk(clk), .reset(reset), .en(en), .wr(wr), .addr(addr),
    .data_in(data_in), .data_out(data_out), .wt(wt),
    .next_sample(next_sample), .ldata(ldata), .rdata(rdata), .irq(irq)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL global_timeout");
    $fatal(1, "bench did not finish");
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // all tasks start and end 1 time unit after a rising edge
  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    bit done = 0;
    en = 1'b1; wr = 1'b1; addr = a; data_in = d;
    for (int i = 0; i < 200 && !done; i++) begin
      #1;
      if (!wt) done = 1;
      @(posedge clk); #1;
    end
    if (!done) check_val("wr_timeout", 32'd1, 32'd0);
    en = 1'b0; wr = 1'b0;
  endtask

  task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
    en = 1'b1; wr = 1'b0; addr = a;
    #1 rd_wt0 = wt;
    @(posedge clk); #1;
    rd_wt1 = wt;
    d = data_out;
    @(posedge clk); #1;
    en = 1'b0;
  endtask

  task automatic pop();
    next_sample = 1'b1;
    @(posedge clk); #1;
    next_sample = 1'b0;
  endtask

  task automatic push_pop(input logic [31:0] d, input string tag);
    en = 1'b1; wr = 1'b1; addr = 2'd0; data_in = d; next_sample = 1'b1;
    #1 check_val(tag, {31'd0, wt}, 32'd0);
    @(posedge clk); #1;
    en = 1'b0; wr = 1'b0; next_sample = 1'b0;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check_val("rst_ldata", {16'd0, ldata}, 32'h0);
    check_val("rst_rdata", {16'd0, rdata}, 32'h0);
    check_val("rst_dout", data_out, 32'h0);
    check_val("rst_wt", {31'd0, wt}, 32'd0);
    check_val("rst_irq", {31'd0, irq}, 32'd0);
    reset = 1'b1;
    @(posedge clk); #1;

    bus_read(2'd1, rd);
    check_val("rst_status", rd, 32'h0001_0000);
    check_val("rd_wt_first", {31'd0, rd_wt0}, 32'd1);
    check_val("rd_wt_second", {31'd0, rd_wt1}, 32'd0);

    // single pair round trip
    bus_write(2'd0, 32'h1234_5678);
    check_val("pre_pop_ldata", {16'd0, ldata}, 32'h0);
    bus_read(2'd1, rd);
    check_val("lvl_one", rd, 32'h0000_0001);
    bus_read(2'd0, rd);
    check_val("data_reads_0", rd, 32'h0);
    pop();
    check_val("pop_ldata", {16'd0, ldata}, 32'h1234);
    check_val("pop_rdata", {16'd0, rdata}, 32'h5678);
    bus_read(2'd1, rd);
    check_val("lvl_zero", rd, 32'h0001_0000);

    // fill, then stall on the 65th write until a pop
    for (int i = 0; i < 64; i++) bus_write(2'd0, {16'h1000 + 16'(i), 16'h2000 + 16'(i)});
    bus_read(2'd1, rd);
    check_val("full_status", rd, 32'h0002_0040);
    en = 1'b1; wr = 1'b1; addr = 2'd0; data_in = 32'hAAAA_5555;
    #1 check_val("wfull_wt", {31'd0, wt}, 32'd1);
    repeat (3) @(posedge clk);
    #1 check_val("wfull_hold", {31'd0, wt}, 32'd1);
    next_sample = 1'b1;
    #1 check_val("wfull_release", {31'd0, wt}, 32'd0);
    @(posedge clk); #1;
    en = 1'b0; wr = 1'b0; next_sample = 1'b0;
    check_val("wfull_pop_l", {16'd0, ldata}, 32'h1000);
    check_val("wfull_pop_r", {16'd0, rdata}, 32'h2000);
    bus_read(2'd1, rd);
    check_val("wfull_level", rd, 32'h0002_0040);
    pop();
    check_val("drain_first", {16'd0, ldata}, 32'h1001);
    for (int i = 0; i < 63; i++) pop();
    check_val("drain_last_l", {16'd0, ldata}, 32'hAAAA);
    check_val("drain_last_r", {16'd0, rdata}, 32'h5555);
    bus_read(2'd1, rd);
    check_val("drain_status", rd, 32'h0001_0000);

    // underruns hold the output and set the sticky bit
    repeat (3) pop();
    check_val("udr_hold_l", {16'd0, ldata}, 32'hAAAA);
    check_val("udr_hold_r", {16'd0, rdata}, 32'h5555);
    bus_read(2'd1, rd);
    check_val("udr_status", rd, 32'h0005_0000);
    bus_read(2'd3, rd);
`ifdef SND_FIFO_STATS_EN
    check_val("udr_count", rd, 32'd3);
`else
    check_val("addr3_zero", rd, 32'd0);
`endif
    bus_write(2'd2, 32'h0004_0000);
    bus_read(2'd1, rd);
    check_val("udr_cleared", rd, 32'h0001_0000);
    en = 1'b1; wr = 1'b1; addr = 2'd2; data_in = 32'h0004_0000; next_sample = 1'b1;
    @(posedge clk); #1;
    en = 1'b0; wr = 1'b0; next_sample = 1'b0;
    bus_read(2'd1, rd);
    check_val("udr_set_wins", rd, 32'h0005_0000);
    bus_write(2'd2, 32'h0004_0000);

    // low-watermark interrupt
    bus_write(2'd2, 32'h0001_0004);
    bus_read(2'd2, rd);
    check_val("ctrl_readback", rd, 32'h0001_0004);
    check_val("irq_lvl0", {31'd0, irq}, 32'd1);
    for (int i = 0; i < 8; i++) bus_write(2'd0, {16'h3000 + 16'(i), 16'h4000 + 16'(i)});
    check_val("irq_lvl8", {31'd0, irq}, 32'd0);
    repeat (3) pop();
    check_val("irq_lvl5", {31'd0, irq}, 32'd0);
    pop();
    check_val("irq_lag", {31'd0, irq}, 32'd0);
    @(posedge clk); #1;
    check_val("irq_rise", {31'd0, irq}, 32'd1);
    bus_write(2'd0, 32'h3008_4008);
    check_val("irq_fall_lag", {31'd0, irq}, 32'd1);
    @(posedge clk); #1;
    check_val("irq_fall", {31'd0, irq}, 32'd0);

    // flush, then simultaneous push/pop at level 0, 1 and 64
    bus_write(2'd2, 32'h0002_0000);
    check_val("flush_ldata", {16'd0, ldata}, 32'h0);
    bus_read(2'd1, rd);
    check_val("flush_status", rd, 32'h0001_0000);
    push_pop(32'h5000_6000, "pp0_wt");
    check_val("pp0_ldata", {16'd0, ldata}, 32'h0);
    bus_read(2'd1, rd);
    check_val("pp0_status", rd, 32'h0004_0001);
    bus_write(2'd2, 32'h0004_0000);
    push_pop(32'h5001_6001, "pp1_wt");
    check_val("pp1_ldata", {16'd0, ldata}, 32'h5000);
    check_val("pp1_rdata", {16'd0, rdata}, 32'h6000);
    bus_read(2'd1, rd);
    check_val("pp1_status", rd, 32'h0000_0001);
    for (int i = 0; i < 63; i++) bus_write(2'd0, {16'h7000 + 16'(i), 16'h8000 + 16'(i)});
    bus_read(2'd1, rd);
    check_val("pp64_pre", rd, 32'h0002_0040);
    push_pop(32'h5002_6002, "pp64_wt");
    check_val("pp64_ldata", {16'd0, ldata}, 32'h5001);
    bus_read(2'd1, rd);
    check_val("pp64_status", rd, 32'h0002_0040);

    // reset in the middle of a full-FIFO stall
    bus_write(2'd2, 32'h0001_0040);
    @(posedge clk); #1;
    check_val("irq_full", {31'd0, irq}, 32'd1);
    en = 1'b1; wr = 1'b1; addr = 2'd0; data_in = 32'hDEAD_BEEF;
    @(posedge clk); #1;
    check_val("stall_wt", {31'd0, wt}, 32'd1);
    reset = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1; en = 1'b0; wr = 1'b0;
    check_val("rst_stall_wt", {31'd0, wt}, 32'd0);
    check_val("rst_stall_irq", {31'd0, irq}, 32'd0);
    check_val("rst_stall_dout", data_out, 32'h0);
    check_val("rst_stall_ldata", {16'd0, ldata}, 32'h0);
    check_val("rst_stall_rdata", {16'd0, rdata}, 32'h0);
    bus_read(2'd1, rd);
    check_val("rst_stall_status", rd, 32'h0001_0000);
    bus_read(2'd2, rd);
    check_val("rst_stall_ctrl", rd, 32'h0);

    // reset during the second read cycle
    bus_write(2'd0, 32'h0BAD_F00D);
    en = 1'b1; wr = 1'b0; addr = 2'd1;
    @(posedge clk); #1;
    check_val("rd1_data", data_out, 32'h0000_0001);
    reset = 1'b0; en = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    check_val("rst_rd1_dout", data_out, 32'h0);
    check_val("rst_rd1_wt", {31'd0, wt}, 32'd0);
    bus_read(2'd1, rd);
    check_val("rst_rd1_status", rd, 32'h0001_0000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
